pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised successor to the fixed-width stage latches (FD/DX/XM/MW). It carries one WIDTH-bit bundle per pipeline stage with a valid/ready handshake, replacing the bare enable pin. It adds a 2-entry skid buffer, so in_ready is a pure function of registered state and never depends combinationally on out_ready. It also provides a flush that inserts bubbles, and an invalid stage drives a configurable NOP.

Parameters:
WIDTH, 64, bundle width in bits (e.g. pc_plus_1 and insn concatenated = 64).
NOP_VALUE, {WIDTH{1'b0}}, value driven on out_data and loaded into both entries on reset/flush (bubble).

Ports:
clock  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous squash of all contents (branch mispredict, exception).
in_valid  in  1  upstream holds a valid bundle.
in_ready  out  1  stage can accept; equals (state != SKID).
in_data  in  WIDTH  upstream bundle.
out_valid  out  1  main entry holds valid bundle.
out_ready  in  1  downstream accepts this cycle.
out_data  out  WIDTH  main entry when out_valid=1; NOP_VALUE otherwise.
occupancy  out  2  entries held: 0, 1 or 2.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- Transfer rules: in transfer = in_valid & in_ready; out transfer = out_valid & out_ready.
- States: EMPTY (occupancy 0), FULL (main only, 1), SKID (main+skid, 2).
- Reset: state EMPTY, main=skid=NOP_VALUE. Outputs: out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0.
- Priority: reset > flush > normal operation.
- Flush: next state EMPTY, both entries <= NOP_VALUE. An in transfer in the flush cycle is dropped; an out transfer in the flush cycle still counts as consumed.
- EMPTY:
  - in transfer -> FULL, main<=in_data.
  - Otherwise stay.
- FULL:
  - in & out -> FULL, main<=in_data.
  - in & !out -> SKID, skid<=in_data, main held.
  - !in & out -> EMPTY, main<=NOP_VALUE.
  - Neither -> hold.
- SKID (in_ready=0):
  - out transfer -> FULL, main<=skid, skid<=NOP_VALUE.
  - Otherwise hold.
- Latency: 1 cycle from in transfer to out_valid when downstream is ready. Throughput 1/cycle with no bubbles while out_ready=1.
- Ordering: strict FIFO; the skid entry is never presented ahead of main.
- Data stability: out_data/out_valid change only on a clock edge.
- Upstream may change in_data while in_ready=0; nothing is sampled.
- in_valid with in_ready=0 is legal and causes no loss.
- No combinational path from out_ready to in_ready, or from in_* to out_*.
- Reset asserted mid-stream: contents are discarded identically to flush.

Optional Feature:
Macro PIPE_STAGE_EXC_EN.
- Defined:
  - Adds ports exc_in (in, 1) and exc_out (out, 1).
  - A write-exception sideband bit travels with each bundle through main/skid entries under the same transfer rules.
  - Reset/flush clear it.
  - exc_out=0 whenever out_valid=0.
- Undefined: ports are absent and no extra flops are generated.

Decomposition:
- Shared package pipe_pkg:
  - state enum {EMPTY, FULL, SKID} (2-bit encoding 0/1/2, equal to occupancy).
  - Default bundle widths for each stage boundary: FD=64, DX=128, XM=96, MW=96.
  - NOP instruction constant 32'h0.
- Sub-module stage_reg: WIDTH-bit register with load enable and synchronous reset-to-RESET_VAL. Instantiated for main, skid and (optionally) the exception bits.

Test Plan:
- Reset then idle: assert reset 2 cycles -> out_valid=0, out_data=NOP_VALUE, in_ready=1, occupancy=0.
- Streaming: send A=64'h1, B=64'h2, C=64'h3 on consecutive cycles with out_ready=1 -> out_data A,B,C on the following consecutive cycles; occupancy stays 1.
- Backpressure: out_ready=0, send A then B -> occupancy 2, in_ready=0, C held upstream.
  - Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Flush in SKID: with A,B held, pulse flush with in_valid=1 carrying D -> next cycle occupancy=0, out_data=NOP_VALUE; D not delivered.
- Simultaneous in and out in FULL with out_ready=1: main replaced each cycle, occupancy constant at 1.
- PIPE_STAGE_EXC_EN: send A with exc_in=1, B with exc_in=0 under backpressure -> exc_out 1 with A, 0 with B; flush clears exc_out to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: stage state encoding,
// default bundle widths per stage boundary and the NOP instruction word.
package pipe_pkg;

    // State encoding equals the number of entries held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam int unsigned FD_WIDTH = 64;
    localparam int unsigned DX_WIDTH = 128;
    localparam int unsigned XM_WIDTH = 96;
    localparam int unsigned MW_WIDTH = 96;

    localparam logic [31:0] NOP_INSN = 32'h0;

endpackage

// File: rtl/stage_reg.sv
// WIDTH-bit register with load enable and synchronous reset to RESET_VAL.
module stage_reg #(
    parameter int unsigned          WIDTH     = 64,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over load.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on registered state; flush inserts a bubble.
// Optional write-exception sideband enabled by defining PIPE_STAGE_EXC_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = FD_WIDTH,
    parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_EXC_EN
    input  logic             exc_in,
    output logic             exc_out,
`endif
    output logic [1:0]       occupancy
);

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic             main_en;
    logic             skid_en;
    logic             clear;
    logic             in_xfer;
    logic             out_xfer;

    assign clear     = reset | flush;
    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = 2'(state_q);
    // Main entry is reloaded with NOP_VALUE whenever it empties.
    assign out_data  = main_q;
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    // Occupancy state machine.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) state_q <= FULL;
                FULL: begin
                    if (in_xfer && !out_xfer) state_q <= SKID;
                    else if (!in_xfer && out_xfer) state_q <= EMPTY;
                end
                SKID: if (out_xfer) state_q <= FULL;
                default: state_q <= EMPTY;
            endcase
        end
    end

    // Entry load enables and next values.
    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        skid_d  = in_data;
        case (state_q)
            EMPTY: main_en = in_xfer;
            FULL: begin
                if (in_xfer && out_xfer) begin
                    main_en = 1'b1;
                end else if (in_xfer) begin
                    skid_en = 1'b1;
                end else if (out_xfer) begin
                    main_en = 1'b1;
                    main_d  = NOP_VALUE;
                end
            end
            SKID: begin
                if (out_xfer) begin
                    main_en = 1'b1;
                    main_d  = skid_q;
                    skid_en = 1'b1;
                    skid_d  = NOP_VALUE;
                end
            end
            default: ;
        endcase
    end

    stage_reg #(.WIDTH(WIDTH), .RESET_VAL(NOP_VALUE)) u_main (
        .clock (clock),
        .reset (clear),
        .load  (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    stage_reg #(.WIDTH(WIDTH), .RESET_VAL(NOP_VALUE)) u_skid (
        .clock (clock),
        .reset (clear),
        .load  (skid_en),
        .d     (skid_d),
        .q     (skid_q)
    );

`ifdef PIPE_STAGE_EXC_EN
    logic exc_main_q;
    logic exc_skid_q;
    logic exc_main_d;
    logic exc_skid_d;

    // Sideband follows the same moves as the data entries.
    always_comb begin
        exc_main_d = exc_in;
        exc_skid_d = exc_in;
        if (state_q == FULL && !in_xfer) begin
            exc_main_d = 1'b0;
        end else if (state_q == SKID) begin
            exc_main_d = exc_skid_q;
            exc_skid_d = 1'b0;
        end
    end

    stage_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_exc_main (
        .clock (clock),
        .reset (clear),
        .load  (main_en),
        .d     (exc_main_d),
        .q     (exc_main_q)
    );

    stage_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_exc_skid (
        .clock (clock),
        .reset (clear),
        .load  (skid_en),
        .d     (exc_skid_d),
        .q     (exc_skid_q)
    );

    assign exc_out = exc_main_q & out_valid;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a FIFO scoreboard of accepted
// bundles predicts every output each cycle.
module tb_pipe_stage_skid;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] NOP = 64'h0;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } item_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
    logic         exc_drv;
`ifdef PIPE_STAGE_EXC_EN
    logic         exc_out;
`endif

    item_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    last_acc;

    always #5 clock = ~clock;

    pipe_stage_skid #(.WIDTH(W), .NOP_VALUE(NOP)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_STAGE_EXC_EN
        .exc_in    (exc_drv),
        .exc_out   (exc_out),
`endif
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare all outputs with the scoreboard prediction.
    task automatic check_outputs(input string tag);
        int n;
        n = sb.size();
        check({tag, ".occupancy"}, 64'(occupancy), 64'(n));
        check({tag, ".in_ready"},  64'(in_ready),  64'(n < 2));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(n > 0));
        check({tag, ".out_data"},  out_data, (n > 0) ? sb[0].d : NOP);
`ifdef PIPE_STAGE_EXC_EN
        check({tag, ".exc_out"},   64'(exc_out), 64'((n > 0) ? sb[0].e : 1'b0));
`endif
    endtask

    // Advance one clock: update the scoreboard at the edge, check at negedge.
    task automatic cycle(input string tag);
        bit in_acc, out_acc;
        item_t it;
        @(posedge clock);
        in_acc  = in_valid && (sb.size() < 2);
        out_acc = (sb.size() > 0) && out_ready;
        last_acc = in_acc && !reset && !flush;
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_acc) void'(sb.pop_front());
            if (in_acc) begin
                it.d = in_data;
                it.e = exc_drv;
                sb.push_back(it);
            end
        end
        @(negedge clock);
        check_outputs(tag);
    endtask

    // Present one bundle until accepted, bounded.
    task automatic send(input string tag, input logic [W-1:0] d, input logic e);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        exc_drv  = e;
        k = 0;
        last_acc = 1'b0;
        while (!last_acc && k < 20) begin
            cycle(tag);
            k++;
        end
        if (!last_acc) check({tag, ".accept_timeout"}, 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; exc_drv = 1'b0;

        // Reset then idle.
        @(negedge clock);
        cycle("reset");
        cycle("reset");
        reset = 1'b0;
        cycle("idle");

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        send("stream", 64'h1, 1'b0);
        send("stream", 64'h2, 1'b0);
        send("stream", 64'h3, 1'b0);
        cycle("stream_drain");
        cycle("stream_drain");

        // Backpressure: fill both entries, hold C, then release.
        out_ready = 1'b0;
        send("bp", 64'hA, 1'b0);
        send("bp", 64'hB, 1'b0);
        in_valid = 1'b1; in_data = 64'hC;
        cycle("bp_hold");
        in_data = 64'hDEAD;
        cycle("bp_hold");
        in_data = 64'hC;
        out_ready = 1'b1;
        send("bp_release", 64'hC, 1'b0);
        repeat (3) cycle("bp_drain");

        // Flush while in SKID with a bundle offered.
        out_ready = 1'b0;
        send("fl", 64'hA1, 1'b0);
        send("fl", 64'hB1, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 64'hD1;
        cycle("flush");
        flush = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1;
        cycle("post_flush");

        // Back-to-back replacement in FULL.
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 64'h100 + 64'(i);
            cycle("full_replace");
        end
        in_valid = 1'b0;
        cycle("full_replace_drain");

        // Exception sideband under backpressure, then flush clears it.
        out_ready = 1'b0;
        send("exc", 64'hE1, 1'b1);
        send("exc", 64'hE2, 1'b0);
        out_ready = 1'b1;
        cycle("exc_pop");
        out_ready = 1'b0;
        send("exc", 64'hE3, 1'b1);
        cycle("exc_hold");
        cycle("exc_hold");
        flush = 1'b1;
        cycle("exc_flush");
        flush = 1'b0;
        exc_drv = 1'b0;

        // Mid-stream reset.
        send("mid_rst", 64'hF1, 1'b0);
        send("mid_rst", 64'hF2, 1'b1);
        reset = 1'b1;
        cycle("mid_reset");
        reset = 1'b0;
        cycle("mid_reset_idle");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = {$urandom, $urandom};
            exc_drv   = 1'($urandom_range(0, 1));
            cycle("random");
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) cycle("final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
